ycr_dmem_router_np: RTL

Parametrised N-port data-memory router between the core DMEM interface and NPORT memory/peripheral targets. It decodes each request address against per-port mask/pattern pairs and forwards the request to one port. It tracks up to OUTSTD accepted-but-unanswered requests in a port-index FIFO and returns responses strictly in request order. Unmapped addresses go either to port 0 (default) or to an internal error responder. It sits in the core top between the LSU DMEM interface and the TCM/timer/WB bridges.

---
 rtl/ycr_dmem_router_np_pkg.sv | 14 +
 rtl/ycr_router_sel_fifo.sv | 56 +++++
 rtl/ycr_dmem_router_np.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ycr_dmem_router_np_pkg.sv
// Shared DMEM response encodings and router index-width helper.
package ycr_dmem_router_np_pkg;

    localparam logic [1:0] RESP_NOTRDY  = 2'b00;
    localparam logic [1:0] RESP_RDY_OK  = 2'b01;
    localparam logic [1:0] RESP_RDY_ER  = 2'b10;
    localparam logic [1:0] RESP_RDY_LOK = 2'b11;

    // Port indices 0..NPORT-1 plus one extra code (NPORT) for the error responder.
    function automatic int idx_w(input int nport);
        return $clog2(nport + 1);
    endfunction

endpackage

// File: rtl/ycr_router_sel_fifo.sv
// Port-index FIFO for outstanding DMEM requests; exposes head and last-pushed (tail) entries.
module ycr_router_sel_fifo
    import ycr_dmem_router_np_pkg::*;
#(
    parameter int W     = 3,
    parameter int DEPTH = 2
) (
    input  logic         rst_n,
    input  logic         clk,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head,
    output logic [W-1:0] tail
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [W-1:0]  tail_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            tail_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                tail_q      <= din;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];
    assign tail  = tail_q;

endmodule

// File: rtl/ycr_dmem_router_np.sv
// N-port DMEM router: address decode, in-order issue gate, response mux and error responder.
module ycr_dmem_router_np
    import ycr_dmem_router_np_pkg::*;
#(
    parameter int                   NPORT        = 4,
    parameter int                   OUTSTD       = 2,
    parameter int                   AW           = 32,
    parameter int                   DW           = 32,
    parameter int                   BLW          = 3,
    parameter logic [NPORT*AW-1:0]  ADDR_MASK    = {NPORT{32'hFFFF0000}},
    parameter logic [NPORT*AW-1:0]  ADDR_PATTERN = '0,
    parameter logic [NPORT-1:0]     LOK_MASK     = '1,
    parameter bit                   ERR_EN       = 1'b0
) (
    input  logic                  rst_n,
    input  logic                  clk,
    input  logic                  dmem_req,
    output logic                  dmem_req_ack,
    input  logic                  dmem_cmd,
    input  logic [BLW-1:0]        dmem_bl,
    input  logic [1:0]            dmem_width,
    input  logic [AW-1:0]         dmem_addr,
    input  logic [DW-1:0]         dmem_wdata,
    output logic [DW-1:0]         dmem_rdata,
    output logic [1:0]            dmem_resp,
    output logic [NPORT-1:0]      port_req,
    input  logic [NPORT-1:0]      port_req_ack,
    output logic                  port_cmd,
    output logic [BLW-1:0]        port_bl,
    output logic [1:0]            port_width,
    output logic [AW-1:0]         port_addr,
    output logic [DW-1:0]         port_wdata,
    input  logic [NPORT*DW-1:0]   port_rdata,
    input  logic [NPORT*2-1:0]    port_resp
);

    localparam int               IDXW    = idx_w(NPORT);
    localparam logic [IDXW-1:0]  ERR_IDX = IDXW'(NPORT);

    logic [IDXW-1:0] target;
    logic [IDXW-1:0] head_idx;
    logic [IDXW-1:0] tail_idx;
    logic            fifo_full;
    logic            fifo_empty;
    logic            can_issue;
    logic            ack_sel;
    logic            push;
    logic            pop;

    // Descending scan so the lowest matching index wins; port 0 is only the fallback.
    always_comb begin
        target = ERR_EN ? ERR_IDX : '0;
        for (int i = NPORT - 1; i >= 1; i--)
            if ((dmem_addr & ADDR_MASK[i*AW +: AW]) == ADDR_PATTERN[i*AW +: AW])
                target = IDXW'(i);
    end

    // Switching targets waits for the FIFO to drain, which keeps responses in order.
    assign can_issue = !fifo_full && (fifo_empty || target == tail_idx);

    for (genvar t = 0; t < NPORT; t++) begin : g_req
        assign port_req[t] = dmem_req & can_issue & (target == IDXW'(t));
    end

    always_comb begin
        ack_sel = 1'b0;
        if (target == ERR_IDX)
            ack_sel = 1'b1;
        else
            for (int i = 0; i < NPORT; i++)
                if (target == IDXW'(i)) ack_sel = port_req_ack[i];
    end

    assign dmem_req_ack = can_issue & ack_sel;
    assign push         = dmem_req & dmem_req_ack;

    assign port_cmd   = dmem_cmd;
    assign port_bl    = dmem_bl;
    assign port_width = dmem_width;
    assign port_addr  = dmem_addr;
    assign port_wdata = dmem_wdata;

    always_comb begin
        dmem_resp  = RESP_NOTRDY;
        dmem_rdata = '0;
        if (!fifo_empty) begin
            if (head_idx == ERR_IDX) begin
                dmem_resp = RESP_RDY_ER;
            end else begin
                for (int i = 0; i < NPORT; i++) begin
                    if (head_idx == IDXW'(i)) begin
                        dmem_resp  = port_resp[2*i +: 2];
                        dmem_rdata = port_rdata[DW*i +: DW];
                        if (LOK_MASK[i] && dmem_resp == RESP_RDY_OK)
                            dmem_resp = RESP_RDY_LOK;
                    end
                end
            end
        end
    end

    assign pop = (dmem_resp == RESP_RDY_LOK) || (dmem_resp == RESP_RDY_ER);

    ycr_router_sel_fifo #(
        .W     (IDXW),
        .DEPTH (OUTSTD)
    ) u_sel_fifo (
        .rst_n (rst_n),
        .clk   (clk),
        .push  (push),
        .pop   (pop),
        .din   (target),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head_idx),
        .tail  (tail_idx)
    );

    // Only the head port may answer; anything else is a target protocol violation.
    for (genvar i = 0; i < NPORT; i++) begin : g_chk
        a_stray_resp: assert property (@(posedge clk) disable iff (!rst_n)
            (fifo_empty || head_idx != IDXW'(i)) |-> (port_resp[2*i +: 2] == RESP_NOTRDY));
    end

endmodule
